// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among producers
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int ID_W      = 3
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_data,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

   logic [2*NUM_REQ-1:0] valid_dbl;
   logic [NUM_REQ-1:0]   valid_rot;
   logic [IDX_W:0]       cand;
   logic [IDX_W-1:0]     winner;
   logic                 own_valid;
   logic                 own_last;
   logic [DATA_W-1:0]    own_data;
   logic                 transfer;

   // Rotate requests so bit 0 is rr_ptr; the lowest set bit wins, mapped back modulo NUM_REQ.
   always_comb begin
      valid_dbl = {req_valid, req_valid};
      valid_rot = NUM_REQ'(valid_dbl >> rr_ptr_q);
      winner    = '0;
      cand      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (valid_rot[i]) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
               cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            winner = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            own_valid    = req_valid[i];
            own_last     = req_last[i];
            own_data     = req_data[i*DATA_W +: DATA_W];
            req_ready[i] = (state_q == GRANT) && !fifo_full;
         end
      end
      transfer   = (state_q == GRANT) && own_valid && !fifo_full;
      fifo_wr_en = transfer;
      fifo_data  = (state_q == GRANT) ? own_data : '0;
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d    = GRANT;
               owner_d    = winner;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            // Owner keeps the grant, even with valid low, until last or the burst cap.
            if (transfer) begin
               if (own_last || (beat_cnt_q == CNT_MAX)) begin
                  state_d    = IDLE;
                  rr_ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign grant_id = ID_W'(owner_q);
   assign busy     = (state_q == GRANT);

endmodule
